sample_queue: RTL
=================

SAMPLE_QUEUE -- requirements
Module: sample_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 1536, meaning circular buffer entries per channel.
REQ-002 SHALL have parameter READ_LEN, default 1021, meaning samples per readout window (FIR tap count); DEPTH > READ_LEN+1 required.
REQ-003 SHALL have port clk  input  1  the single system clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wrt_smpl  input  1  one-cycle strobe: new stereo sample present.
REQ-006 SHALL have port lft_smpl  input  16  signed left sample, valid with wrt_smpl.
REQ-007 SHALL have port rght_smpl  input  16  signed right sample, valid with wrt_smpl.
REQ-008 SHALL have port sequencing  output  1  high exactly while lft_out/rght_out carry a readout sample.
REQ-009 SHALL have port lft_out  output  16  signed left readout sample.
REQ-010 SHALL have port rght_out  output  16  signed right readout sample.

Function
REQ-011 SHALL write {lft_smpl,rght_smpl} at new_ptr on every wrt_smpl cycle regardless of state, then advance new_ptr by 1, wrapping DEPTH-1 -> 0.
REQ-012 SHALL keep fill count, incremented per write, saturating at READ_LEN; no readout until fill reaches READ_LEN.
REQ-013 SHALL implement states IDLE and READ; IDLE -> READ in the cycle after a write that leaves fill == READ_LEN (or on pending, REQ-017); rd_ptr loaded with old_ptr.
REQ-014 SHALL in READ present rd_ptr to the RAM each cycle, advancing by 1 with wrap, for READ_LEN addresses.
REQ-015 SHALL assert sequencing for exactly READ_LEN consecutive cycles, first cycle = 2 cycles after the triggering wrt_smpl; oldest sample first, newest last.
REQ-016 SHALL at readout end advance old_ptr by 1 (wrap) and return to IDLE; sequencing low at least 1 cycle between readouts.
REQ-017 SHALL, on wrt_smpl during READ, write the sample and set pending; a second readout starts immediately after the current one ends.
REQ-018 SHALL, on wrt_smpl while pending already set, discard the extra readout request (write still performed).
REQ-019 SHALL force lft_out/rght_out to 0 whenever sequencing is low.
REQ-020 SHALL never read and write the same address in one cycle (guaranteed by DEPTH > READ_LEN+1).

Reset
REQ-021 SHALL on rst_n low: state IDLE, new_ptr/old_ptr/rd_ptr 0, fill 0, pending 0, sequencing 0, lft_out/rght_out 0.
REQ-022 SHALL abort a readout in progress on reset; RAM contents need not be cleared.

Configuration
REQ-023 SHALL, with SAMPLE_QUEUE_OVERRUN_EN defined, add output overrun (1 bit, reset 0), set sticky on a REQ-018 event, cleared only by reset.
REQ-024 SHALL, without SAMPLE_QUEUE_OVERRUN_EN, omit the overrun port; REQ-018 behaviour unchanged.

Structure
REQ-025 SHALL place state_t {IDLE,READ}, DEPTH, READ_LEN and PTR_W = clog2(DEPTH) in package sample_queue_pkg.
REQ-026 SHALL instantiate one sub-module dp_ram_sq: DEPTH x 32 dual-port, sync write, sync read, 1-cycle read latency, no reset.

Verification
REQ-027 SHALL cover fill: 1021 writes of lft=n, rght=-n (n=1..1021), one per 1100 cycles -> no sequencing through write 1020; after write 1021 sequencing 1021 cycles, lft_out 1..1021, rght_out -1..-1021.
REQ-028 SHALL cover sliding: write 1022 -> readout lft_out 2..1022; sequencing start exactly 2 cycles after strobe.
REQ-029 SHALL cover wrap: 2000 writes -> each readout is the newest 1021 values, contiguous across pointer wrap at 1535 -> 0.
REQ-030 SHALL cover back-to-back: wrt_smpl 500 cycles into a readout -> second 1021-cycle readout follows after a 1-cycle gap, shifted by one sample; third strobe in same readout -> discarded, overrun=1 when SAMPLE_QUEUE_OVERRUN_EN.
REQ-031 SHALL cover reset mid-readout: rst_n low at readout cycle 300 -> sequencing, outputs 0 immediately; 1020 following writes produce no sequencing.

Source files
------------

// File: rtl/sample_queue_pkg.sv
// sample_queue_pkg -- shared types and default sizing for the sample_queue block.
//   state_t  : readout sequencer states (IDLE, READ)
//   DEPTH    : default circular buffer entries per channel
//   READ_LEN : default samples per readout window (FIR tap count)
//   PTR_W    : pointer width for the default DEPTH
package sample_queue_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam int unsigned DEPTH    = 1536;
    localparam int unsigned READ_LEN = 1021;
    localparam int unsigned PTR_W    = $clog2(DEPTH);

endpackage

// File: rtl/dp_ram_sq.sv
// dp_ram_sq -- DEPTH x W simple dual-port RAM, synchronous write, synchronous
// read with one cycle of latency, no reset on storage or read data.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable (read data holds when low)
//   raddr_i : read address
//   rdata_o : registered read data
module dp_ram_sq
    import sample_queue_pkg::*;
#(
    parameter int unsigned DEPTH = sample_queue_pkg::DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned W     = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port: store the incoming word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: one-cycle registered read.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/sample_queue.sv
// sample_queue -- stereo sample history buffer feeding a FIR engine.
// Every strobed sample is stored in a circular buffer. Once READ_LEN samples
// are held, each new sample triggers a readout of the newest READ_LEN samples,
// oldest first, with 'sequencing' high while the outputs carry data.
//   clk        : system clock (rising edge)
//   rst_n      : asynchronous active-low reset
//   wrt_smpl   : one-cycle strobe, new stereo sample present
//   lft_smpl   : signed left sample
//   rght_smpl  : signed right sample
//   sequencing : high while lft_out/rght_out carry a readout sample
//   lft_out    : signed left readout sample (0 when not sequencing)
//   rght_out   : signed right readout sample (0 when not sequencing)
//   overrun    : sticky, a readout request was dropped (only with
//                SAMPLE_QUEUE_OVERRUN_EN defined)
module sample_queue
    import sample_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = sample_queue_pkg::DEPTH,
    parameter int unsigned READ_LEN = sample_queue_pkg::READ_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wrt_smpl,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rght_smpl,
    output logic               sequencing,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rght_out
`ifdef SAMPLE_QUEUE_OVERRUN_EN
   ,output logic               overrun
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(READ_LEN + 1);

    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FILL_FULL = CW'(READ_LEN);
    localparam logic [CW-1:0] FILL_PRE  = CW'(READ_LEN - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(READ_LEN - 1);

    // Circular pointer increment, wrapping DEPTH-1 -> 0.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == PTR_LAST) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1'b1);
        end
    endfunction

    state_t        state_q,   state_d;
    logic [AW-1:0] new_ptr_q, new_ptr_d;
    logic [AW-1:0] old_ptr_q, old_ptr_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0] fill_q,    fill_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          pending_q, pending_d;
    logic          seq_q;
    logic          req_s;
    logic [31:0]   rdata_s;
`ifdef SAMPLE_QUEUE_OVERRUN_EN
    logic          overrun_q, overrun_d;
`endif

    // A write asks for a readout when it leaves the buffer holding a full window.
    assign req_s = wrt_smpl && ((fill_q == FILL_FULL) || (fill_q == FILL_PRE));

    // Next-state logic for pointers, fill level and readout sequencer.
    always_comb begin
        state_d   = state_q;
        new_ptr_d = new_ptr_q;
        old_ptr_d = old_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
`ifdef SAMPLE_QUEUE_OVERRUN_EN
        overrun_d = overrun_q;
`endif

        if (wrt_smpl) begin
            new_ptr_d = ptr_inc(new_ptr_q);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + CW'(1'b1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            new_ptr_d = new_ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (pending_q || req_s) begin
                    state_d   = READ;
                    rd_ptr_d  = old_ptr_q;
                    cnt_d     = {CW{1'b0}};
                    // A write landing while a pending readout launches stays queued.
                    pending_d = pending_q && req_s;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                cnt_d    = cnt_q + CW'(1'b1);
                if (req_s) begin
                    if (pending_q) begin
                        // Only one readout can be queued; this request is dropped.
`ifdef SAMPLE_QUEUE_OVERRUN_EN
                        overrun_d = 1'b1;
`else
                        pending_d = pending_q;
`endif
                    end else begin
                        pending_d = 1'b1;
                    end
                end else begin
                    pending_d = pending_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    old_ptr_d = ptr_inc(old_ptr_q);
                end else begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            new_ptr_q <= {AW{1'b0}};
            old_ptr_q <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            fill_q    <= {CW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            new_ptr_q <= new_ptr_d;
            old_ptr_q <= old_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // Sequencing follows READ by one cycle to line up with RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= 1'b0;
        end else begin
            seq_q <= (state_q == READ);
        end
    end

`ifdef SAMPLE_QUEUE_OVERRUN_EN
    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    // Dropped readout requests are not reported in this build.
`endif

    dp_ram_sq #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (32)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wrt_smpl),
        .waddr_i (new_ptr_q),
        .wdata_i ({lft_smpl, rght_smpl}),
        .re_i    (state_q == READ),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    // Registered RAM data is masked so the outputs read 0 outside a readout,
    // including immediately on reset.
    assign sequencing = seq_q;
    assign lft_out    = seq_q ? $signed(rdata_s[31:16]) : 16'sd0;
    assign rght_out   = seq_q ? $signed(rdata_s[15:0])  : 16'sd0;

endmodule
